// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared state encodings and constants for the instruction-fetch responder
package imem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int CNT_W = 4;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: 2**ADDR_W x 32 instruction array, one sync write port, one enabled registered read port
module imem_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-fetch responder with wait states, error decode, flush and loader port
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] raddr;
  logic              err_q;
  logic              accept;
  logic              bad;
  logic              enter_resp;
  logic [31:0]       rdata;
  assign req_ready  = !load_en && !flush && !rst && (state == IDLE || (state == RESP && rsp_ready));
  assign accept     = req_valid && req_ready;
  assign bad        = |req_addr[1:0] || |req_addr[31:ADDR_W+2];
  assign enter_resp = WAIT_CYCLES == 0 ? accept : (state == WAIT && cnt == '0 && !flush && !rst);
  assign raddr      = WAIT_CYCLES == 0 ? req_addr[ADDR_W+1:2] : addr_q;
  assign rsp_valid  = state == RESP;
  assign rsp_err    = rsp_valid && err_q;
  assign rsp_inst   = !rsp_valid ? '0 : err_q ? NOP_INST : rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state  <= WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt    <= RELOAD;
      addr_q <= req_addr[ADDR_W+1:2];
      err_q  <= bad;
    end else if (state == WAIT) begin
      state <= cnt == '0 ? RESP : WAIT;
      cnt   <= cnt == '0 ? cnt : cnt - 1'b1;
    end else if (state == RESP && rsp_ready) begin
      state <= IDLE;
    end
  end
  imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (enter_resp),
    .raddr (raddr),
    .rdata (rdata)
  );
endmodule
